i2c_eeprom_responder: RTL and testbench

I2C target that behaves as the DE0-Nano 256 x 8 serial EEPROM: 7-bit device address 0x50, so 0xA0 for write and 0xA1 for read. The block oversamples SCL/SDA on the system clock, detects START and STOP, and acknowledges its device address. It supports byte and sequential writes, current-address reads, random reads (write of word address, repeated START, read) and sequential reads. It is the bus-side counterpart to the EEPROM controller and serves both as the simulation target for that controller and as an FPGA-resident EEPROM emulator.

---
 rtl/i2c_eeprom_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_eeprom_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 256 x 8 serial EEPROM: byte/sequential writes, current-address,
// random and sequential reads. SCL/SDA are oversampled on clk; SDA is driven open-drain.
`timescale 1ns/1ps
module i2c_eeprom_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StDevAck, StWordAddr, StWordAck,
    StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_q, sda_q;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d, shift_in;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        mem_we;
  logic [7:0]  rd_byte;
  logic [7:0]  mem [256];

  // Synchronizers reset to the idle-bus level so reset release never looks like START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_q      <= scl_sync_q[1];
      sda_q      <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};
  assign rd_byte   = mem[ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (start_det) begin
      state_d  = StDevAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        StDevAddr, StWordAddr, StWrData: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == StDevAddr) begin
                if (shift_in[7:1] == DEV_ADDR) begin
                  state_d = StDevAck;
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StWordAddr) begin
                ptr_d   = shift_in;
                state_d = StWordAck;
              end else begin
                state_d = StWrAck;
              end
            end
          end
        end
        // In ACK states sda_oe is low on entry, so it doubles as the first/second fall marker.
        StDevAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (shift_q[0]) begin
              shift_d  = rd_byte;
              ptr_d    = ptr_q + 8'd1;
              sda_oe_d = ~rd_byte[7];
              cnt_d    = 4'd0;
              state_d  = StRdData;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWordAddr;
            end
          end
        end
        StWordAck: begin
          if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) state_d = StWrData;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d   = 1'b1;
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_q;
              ptr_d      = ptr_q + 8'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        StRdAck: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda_s) begin
              shift_d = rd_byte;
              ptr_d   = ptr_q + 8'd1;
              cnt_d   = 4'd0;
              state_d = StRdData;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= shift_q;
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Bench for i2c_eeprom_responder: bit-banged I2C master, wired-AND SDA, scoreboard queues
// for committed writes and read data.
`timescale 1ns/1ps
module tb_i2c_eeprom_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl, sda_in, sda_oe, busy, wr_valid;
  logic [7:0] wr_addr, wr_data;

  assign scl    = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          n_wr_exp = 0;
  int          n_viol = 0;
  logic        prev_oe = 1'b0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Commit monitor and SDA-stability watch (sda_oe must not move while SCL is high).
  always @(negedge clk) begin
    if (rst_n && scl_drv && (sda_oe !== prev_oe)) n_viol++;
    prev_oe = sda_oe;
    if (wr_valid === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) check_eq("wr_extra", 16'(n_wr), 16'(n_wr_exp));
      else check_eq("wr_commit", {wr_addr, wr_data}, wr_q.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    clk_wait(4);
    scl_drv = 1'b1;
    clk_wait(6);
    sda_drv = 1'b0;
    clk_wait(6);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    clk_wait(4);
    sda_drv = 1'b0;
    clk_wait(4);
    scl_drv = 1'b1;
    clk_wait(6);
    sda_drv = 1'b1;
    clk_wait(6);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    clk_wait(4);
    sda_drv = b;
    clk_wait(4);
    scl_drv = 1'b1;
    clk_wait(4);
    r = sda_in;
    clk_wait(4);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(~m_ack, r);
  endtask

  task automatic do_write(input logic [7:0] addr);
    logic       ack;
    logic [7:0] a;
    logic [7:0] d;
    a = addr;
    i2c_start();
    send_byte(8'hA0, ack);
    check_eq("wr_dev_ack", 16'(ack), 16'h1);
    check_eq("wr_busy", 16'(busy), 16'h1);
    send_byte(addr, ack);
    check_eq("wr_word_ack", 16'(ack), 16'h1);
    while (tx_q.size() > 0) begin
      d = tx_q.pop_front();
      wr_q.push_back({a, d});
      n_wr_exp++;
      send_byte(d, ack);
      check_eq("wr_data_ack", 16'(ack), 16'h1);
      a = a + 8'd1;
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic rnd, input logic [7:0] addr, input int n);
    logic       ack;
    logic [7:0] d;
    if (rnd) begin
      i2c_start();
      send_byte(8'hA0, ack);
      check_eq("rd_dev_w_ack", 16'(ack), 16'h1);
      send_byte(addr, ack);
      check_eq("rd_word_ack", 16'(ack), 16'h1);
    end
    i2c_start();
    send_byte(8'hA1, ack);
    check_eq("rd_dev_r_ack", 16'(ack), 16'h1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      check_eq("rd_data", 16'(d), 16'(rd_q.pop_front()));
    end
    check_eq("rd_busy_nack", 16'(busy), 16'h0);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] part;

    clk_wait(3);
    #1;
    check_eq("rst_sda_oe", 16'(sda_oe), 16'h0);
    check_eq("rst_busy", 16'(busy), 16'h0);
    check_eq("rst_wr_valid", 16'(wr_valid), 16'h0);
    check_eq("rst_wr_addr", 16'(wr_addr), 16'h0);
    check_eq("rst_wr_data", 16'(wr_data), 16'h0);
    rst_n = 1'b1;
    clk_wait(5);

    // Byte writes, then random read and a current-address read proving ptr = 0x11.
    tx_q.push_back(8'h3C);
    do_write(8'h10);
    tx_q.push_back(8'h77);
    do_write(8'h11);
    rd_q.push_back(8'h3C);
    do_read(1'b1, 8'h10, 1);
    rd_q.push_back(8'h77);
    do_read(1'b0, 8'h00, 1);

    // Sequential write across the 0xFF -> 0x00 wrap, then sequential read back.
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    tx_q.push_back(8'hCC);
    do_write(8'hFE);
    rd_q.push_back(8'hAA);
    rd_q.push_back(8'hBB);
    rd_q.push_back(8'hCC);
    do_read(1'b1, 8'hFE, 3);
    tx_q.push_back(8'h5A);
    do_write(8'h01);

    // Address mismatch: no ACK, not busy, later bytes ignored until START.
    i2c_start();
    send_byte(8'hA4, ack);
    check_eq("mis_ack", 16'(ack), 16'h0);
    check_eq("mis_busy", 16'(busy), 16'h0);
    send_byte(8'hA0, ack);
    check_eq("mis_ignored", 16'(ack), 16'h0);
    i2c_stop();

    // Partial data byte followed by STOP: discarded.
    i2c_start();
    send_byte(8'hA0, ack);
    check_eq("abort_dev_ack", 16'(ack), 16'h1);
    send_byte(8'h10, ack);
    check_eq("abort_word_ack", 16'(ack), 16'h1);
    part = 8'h81;
    for (int i = 7; i >= 3; i--) i2c_bit(part[i], r);
    i2c_stop();
    check_eq("abort_busy", 16'(busy), 16'h0);
    rd_q.push_back(8'h3C);
    do_read(1'b1, 8'h10, 1);

    // Reset in the middle of a read while the responder pulls SDA low.
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h10, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    check_eq("rst_rd_ack", 16'(ack), 16'h1);
    i2c_bit(1'b1, r);
    check_eq("rst_rd_bit7", 16'(r), 16'h0);
    clk_wait(6);
    check_eq("rst_pre_oe", 16'(sda_oe), 16'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_oe", 16'(sda_oe), 16'h0);
    check_eq("rst_mid_busy", 16'(busy), 16'h0);
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(4);
    i2c_stop();

    // Current-address reads after reset: ptr restarts at 0x00, memory kept.
    rd_q.push_back(8'hCC);
    do_read(1'b0, 8'h00, 1);
    rd_q.push_back(8'h5A);
    do_read(1'b0, 8'h00, 1);

    clk_wait(10);
    check_eq("wr_pending", 16'(wr_q.size()), 16'h0);
    check_eq("wr_count", 16'(n_wr), 16'(n_wr_exp));
    check_eq("sda_stable_scl_high", 16'(n_viol), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
